// File: rtl/seq_counter_if.sv
// Bundle of control, table-write and status signals for seq_counter.
// The master drives the controls; the slave (the counter) drives out/idx/wrap.
interface seq_counter_if #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned IW = $clog2(DEPTH);

    logic             en;
    logic             dir;
    logic [IW-1:0]    last_idx;
    logic             load;
    logic [IW-1:0]    load_idx;
    logic             wr_en;
    logic [IW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] out;
    logic [IW-1:0]    idx;
    logic             wrap;

    modport master (
        output en, dir, last_idx, load, load_idx, wr_en, wr_addr, wr_data,
        input  out, idx, wrap
    );

    modport slave (
        input  en, dir, last_idx, load, load_idx, wr_en, wr_addr, wr_data,
        output out, idx, wrap
    );
endinterface

// File: rtl/seq_counter.sv
// Programmable-sequence counter: steps a pointer through a loadable code table.
// Define SEQ_COUNTER_REVERSE_EN to honour bus.dir (reverse stepping).
module seq_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8
) (
    input logic        clk,
    input logic        reset,
    seq_counter_if.slave bus
);
    localparam int unsigned IW = $clog2(DEPTH);

    logic [IW-1:0]    ptr_q, ptr_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] table_q [DEPTH];

    // Out-of-range pointer (last_idx lowered under it) counts as "at the end".
    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            ptr_d = (bus.load_idx <= bus.last_idx) ? bus.load_idx : '0;
        end else if (bus.en) begin
`ifdef SEQ_COUNTER_REVERSE_EN
            if (bus.dir) begin
                if ((ptr_q != '0) && (ptr_q <= bus.last_idx)) begin
                    ptr_d = ptr_q - 1'b1;
                end else begin
                    ptr_d  = bus.last_idx;
                    wrap_d = 1'b1;
                end
            end else
`endif
            if (ptr_q < bus.last_idx) begin
                ptr_d = ptr_q + 1'b1;
            end else begin
                ptr_d  = '0;
                wrap_d = 1'b1;
            end
        end
    end

`ifndef SEQ_COUNTER_REVERSE_EN
    logic unused_dir;
    assign unused_dir = bus.dir;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= WIDTH'(i);
            end
        end else if (bus.wr_en) begin
            table_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.out  = table_q[ptr_q];
    assign bus.idx  = ptr_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_seq_counter.sv
// Self-checking bench for seq_counter: spec-level model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_seq_counter;
    localparam int unsigned WIDTH = 3;
    localparam int unsigned DEPTH = 8;
`ifdef SEQ_COUNTER_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_counter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    seq_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    int m_ptr;
    bit m_wrap;
    int m_tab [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pin(input string name, input int eo, input int ei, input int ew);
        check({name, "_out"},  32'(bus.out),  eo);
        check({name, "_idx"},  32'(bus.idx),  ei);
        check({name, "_wrap"}, 32'(bus.wrap), ew);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("model_out",  32'(bus.out),  m_tab[m_ptr]);
            check("model_idx",  32'(bus.idx),  m_ptr);
            check("model_wrap", 32'(bus.wrap), 32'(m_wrap));
        end
    end

    // One clock: model sees the same inputs as the DUT, state lands after the edge.
    task automatic cycle();
        int np;
        bit nw;
        int nt [DEPTH];
        int last;
        np = m_ptr;
        nw = 1'b0;
        nt = m_tab;
        last = int'(bus.last_idx);
        if (reset) begin
            np = 0;
            for (int i = 0; i < DEPTH; i++) nt[i] = i % (1 << WIDTH);
        end else begin
            if (bus.wr_en) nt[bus.wr_addr] = int'(bus.wr_data);
            if (bus.load) begin
                np = (int'(bus.load_idx) <= last) ? int'(bus.load_idx) : 0;
            end else if (bus.en) begin
                if (REV && bus.dir) begin
                    if (m_ptr > 0 && m_ptr <= last) np = m_ptr - 1;
                    else begin np = last; nw = 1'b1; end
                end else begin
                    if (m_ptr < last) np = m_ptr + 1;
                    else begin np = 0; nw = 1'b1; end
                end
            end
        end
        @(posedge clk);
        #1;
        m_ptr  = np;
        m_wrap = nw;
        m_tab  = nt;
        @(negedge clk);
    endtask

    int prog [6] = '{1, 3, 5, 7, 2, 0};
    int prog_seq [7] = '{3, 5, 7, 2, 0, 1, 3};
    int rev_out [3] = '{0, 2, 7};
    int fwd_out [3] = '{3, 6, 7};

    initial begin
        bus.en = 0; bus.dir = 0; bus.load = 0; bus.load_idx = 0; bus.last_idx = 7;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        reset = 1;
        m_ptr = 0; m_wrap = 0;
        for (int i = 0; i < DEPTH; i++) m_tab[i] = i;
        cycle();
        cycle();
        reset = 0;
        checking = 1'b1;
        pin("reset", 0, 0, 0);

        // Default table sweep with wrap back to 0.
        bus.en = 1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            pin("sweep", k % 8, k % 8, (k == 8) ? 1 : 0);
        end
        bus.en = 0;
        cycle();
        pin("idle", 0, 0, 0);

        // Program entries 0..5 and run the shortened sequence.
        bus.wr_en = 1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_addr = 3'(i);
            bus.wr_data = 3'(prog[i]);
            cycle();
        end
        bus.wr_en = 0;
        bus.last_idx = 5;
        pin("prog", 1, 0, 0);
        bus.en = 1;
        for (int k = 0; k < 7; k++) begin
            cycle();
            pin("prog_seq", prog_seq[k], (k + 1) % 6, (k == 5) ? 1 : 0);
        end

        // Load beats en; out-of-range load goes to 0.
        bus.load = 1; bus.load_idx = 3;
        cycle();
        pin("load", 7, 3, 0);
        bus.load_idx = 6;
        cycle();
        pin("load_oor", 1, 0, 0);

        // Lower last_idx under the pointer, then step.
        bus.en = 0; bus.last_idx = 7; bus.load_idx = 6;
        cycle();
        pin("at6", 6, 6, 0);
        bus.load = 0; bus.last_idx = 4; bus.en = 1;
        cycle();
        pin("shrink", 1, 0, 1);

        // Write landing on the new pointer is visible next cycle.
        bus.last_idx = 5; bus.load = 1; bus.load_idx = 1; bus.en = 0;
        cycle();
        pin("at1", 3, 1, 0);
        bus.load = 0; bus.en = 1;
        bus.wr_en = 1; bus.wr_addr = 2; bus.wr_data = 6;
        cycle();
        bus.wr_en = 0;
        pin("wr_step", 6, 2, 0);

        // Direction: table is now 1,3,6,7,2,0,6,7.
        bus.en = 0; bus.load = 1; bus.load_idx = 0;
        cycle();
        bus.load = 0; bus.dir = 1; bus.en = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (REV) pin("dir_rev", rev_out[k], 5 - k, (k == 0) ? 1 : 0);
            else     pin("dir_fwd", fwd_out[k], k + 1, 0);
        end
        bus.dir = 0;

        // last_idx = 0: every step wraps, on consecutive cycles.
        bus.last_idx = 0;
        cycle();
        pin("last0_a", 1, 0, 1);
        cycle();
        pin("last0_b", 1, 0, 1);

        // Reset mid-sequence wins over en and a table write.
        reset = 1; bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 5;
        cycle();
        pin("reset_mid", 0, 0, 0);
        reset = 0; bus.wr_en = 0; bus.en = 0;
        bus.last_idx = 7; bus.load = 1; bus.load_idx = 2;
        cycle();
        pin("table_restored", 2, 2, 0);
        bus.load = 0;
        cycle();
        pin("hold", 2, 2, 0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_counter.md
# seq_counter

Parametrised programmable-sequence counter. It steps through a run-time-loadable table of WIDTH-bit codes, one entry per enabled clock. It supports wrap detection, pointer load and, optionally, reverse stepping. It replaces the fixed-sequence 3-bit counters in the homework designs as the standard sequence generator for test stimulus and simple controllers.

## Interface
- WIDTH, 3, bit width of each sequence code and of `out`
- DEPTH, 8, number of table entries (power of two, ≥2); IW = $clog2(DEPTH)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- en  input  1  advance pointer one step this cycle
- dir  input  1  0 = forward, 1 = reverse (ignored unless SEQ_COUNTER_REVERSE_EN)
- last_idx  input  IW  highest active table index; sequence is entries 0..last_idx
- load  input  1  force pointer to load_idx
- load_idx  input  IW  pointer load value
- wr_en  input  1  write table entry
- wr_addr  input  IW  table write address
- wr_data  input  WIDTH  table write data
- out  output  WIDTH  table[ptr]
- idx  output  IW  current pointer
- wrap  output  1  registered one-cycle pulse when the last step wrapped

## Operation
- State: pointer `ptr` (IW bits), table of DEPTH×WIDTH registers, `wrap` flag register.
- `out` = table[ptr]. `idx` = ptr. Both are decoded from registers only; there is no input-to-output combinational path.
- Per-cycle pointer update, priority highest first:
  - reset: ptr←0, wrap←0, table[i]←i mod 2^WIDTH for all i.
  - load: ptr←load_idx if load_idx ≤ last_idx, else ptr←0. wrap←0.
  - en, forward: ptr←ptr+1 if ptr < last_idx. Otherwise ptr←0 and wrap←1.
  - en, reverse: ptr←ptr−1 if ptr > 0. Otherwise ptr←last_idx and wrap←1.
  - otherwise: ptr holds, wrap←0.
- Out-of-range pointer (last_idx lowered below ptr): `out` still shows table[ptr]. The next forward en step goes to 0 with wrap←1. A reverse step from that state goes to last_idx with wrap←1.
- last_idx = 0: every en step stays at 0 and pulses wrap.
- Table write: on wr_en, table[wr_addr]←wr_data. The write is independent of reset priority except that reset wins: a write in the reset cycle is discarded.
- A write and a step in the same cycle both take effect. The next-cycle `out` reflects the written data if wr_addr equals the new ptr.
- Table writes to entries above last_idx are legal and stored.

## Timing
- Latency: 1 cycle from en/load/wr_en sample edge to updated `out`/`idx`/`wrap`.
- `wrap` is high for exactly the cycle following the wrapping step. It is high on consecutive cycles only when consecutive steps each wrap.
- Reset values: ptr=0, out=0, idx=0, wrap=0, table[i]=i.
- Reset asserted mid-sequence returns to index 0 on the next edge regardless of en/load/wr_en.
- Throughput: one step per clock; no stalls or handshake.

## Configuration
- SEQ_COUNTER_REVERSE_EN defined: `dir` is honoured per the reverse-step rule above.
- Not defined: `dir` is unused and every en step is forward; the reverse decrement and wrap-to-last_idx logic is not synthesised.

## Test plan
- Reset then en held, last_idx=7, default table → out 0,1,…,7,0; wrap high only in the cycle out returns to 0.
- Write table[0..5] = 1,3,5,7,2,0 and set last_idx=5, then en held → out 1,3,5,7,2,0,1; wrap pulses once per pass.
- load with load_idx=3 while en=1 → idx=3 next cycle (load beats en). load_idx=6 with last_idx=5 → idx=0.
- At idx=6, lower last_idx to 4 and pulse en → idx=0, wrap=1.
- wr_en to wr_addr=2 with wr_data=6 while stepping from idx 1 to 2 → out=6 on the next cycle.
- With SEQ_COUNTER_REVERSE_EN: dir=1 from idx=0, last_idx=5 → idx 5,4,3; wrap=1 on the first step. Without the macro: dir=1 still counts up.
